// File: rtl/titan_pipeline_ctrl_if.sv
// Hazard-unit / pipeline side bus of the Titan pipeline sequencing controller.
// The controller takes the slave modport; the hazard unit and pipeline registers take master.
interface titan_pipeline_ctrl_if #(
    parameter int PERF_W = 32
);
    logic              ld_stall_req_i;
    logic              csr_stall_req_i;
    logic              xcall_break_stall_req_i;
    logic              illegal_stall_req_i;
    logic              trap_commit_i;
    logic              imem_ready_i;
    logic              dmem_ready_i;

    logic              if_stall_o;
    logic              id_stall_o;
    logic              ex_stall_o;
    logic              mem_stall_o;
    logic              wb_stall_o;
    logic              id_flush_o;
    logic              ex_flush_o;
    logic              mem_flush_o;
    logic              pc_trap_o;
    logic              drain_timeout_o;
    logic [1:0]        state_o;
    logic [PERF_W-1:0] ld_stall_cnt_o;
    logic [PERF_W-1:0] csr_stall_cnt_o;
    logic [PERF_W-1:0] trap_cnt_o;

    modport master (
        output ld_stall_req_i, csr_stall_req_i, xcall_break_stall_req_i,
               illegal_stall_req_i, trap_commit_i, imem_ready_i, dmem_ready_i,
        input  if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, wb_stall_o,
               id_flush_o, ex_flush_o, mem_flush_o, pc_trap_o, drain_timeout_o,
               state_o, ld_stall_cnt_o, csr_stall_cnt_o, trap_cnt_o
    );

    modport slave (
        input  ld_stall_req_i, csr_stall_req_i, xcall_break_stall_req_i,
               illegal_stall_req_i, trap_commit_i, imem_ready_i, dmem_ready_i,
        output if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, wb_stall_o,
               id_flush_o, ex_flush_o, mem_flush_o, pc_trap_o, drain_timeout_o,
               state_o, ld_stall_cnt_o, csr_stall_cnt_o, trap_cnt_o
    );
endinterface

// File: rtl/titan_pipeline_ctrl.sv
// Titan RV pipeline sequencing controller: per-stage stall/flush and trap drain/redirect.
// Optional performance counters are built only when TITAN_PIPE_PERF_EN is defined.
module titan_pipeline_ctrl #(
    parameter int MAX_DRAIN = 8,
    parameter int PERF_W    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    titan_pipeline_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HAZ   = 2'd1,
        DRAIN = 2'd2,
        REDIR = 2'd3
    } state_t;

    localparam logic [7:0] DRAIN_LAST = 8'(MAX_DRAIN - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] drain_cnt;
    logic [7:0] drain_cnt_next;

    logic       mw;
    logic       hz;
    logic       tr;

    // stall = {if, id, ex, mem, wb}, flush = {id, ex, mem}
    logic [4:0] stall;
    logic [2:0] flush;
    logic       pc_trap;
    logic       drain_timeout;

    assign mw = ~bus.imem_ready_i | ~bus.dmem_ready_i;
    assign hz = bus.ld_stall_req_i | bus.csr_stall_req_i;
    assign tr = bus.xcall_break_stall_req_i | bus.illegal_stall_req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        stall          = '0;
        flush          = '0;
        pc_trap        = 1'b0;
        drain_timeout  = 1'b0;

        // A memory wait holds every stage and freezes all sequencing state
        if (mw) begin
            stall = 5'b11111;
        end else begin
            unique case (state)
                RUN, HAZ: begin
                    if (tr) begin
                        stall[4]   = 1'b1;
                        flush[2]   = 1'b1;
                        state_next = DRAIN;
                    end else if (hz) begin
                        stall[4:3] = 2'b11;
                        flush[1]   = 1'b1;
                        state_next = HAZ;
                    end else begin
                        state_next = RUN;
                    end
                end
                DRAIN: begin
                    stall[4]       = 1'b1;
                    flush[2]       = 1'b1;
                    drain_cnt_next = drain_cnt + 8'd1;
                    if (bus.trap_commit_i) begin
                        state_next = REDIR;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        drain_timeout = 1'b1;
                        state_next    = REDIR;
                    end
                end
                REDIR: begin
                    pc_trap        = 1'b1;
                    flush          = 3'b111;
                    drain_cnt_next = '0;
                    state_next     = RUN;
                end
                default: state_next = RUN;
            endcase
        end

        // Reset must abort a pending redirect, so nothing escapes while it is held
        if (rst_i) begin
            stall         = '0;
            flush         = '0;
            pc_trap       = 1'b0;
            drain_timeout = 1'b0;
        end
    end

    assign bus.if_stall_o      = stall[4];
    assign bus.id_stall_o      = stall[3];
    assign bus.ex_stall_o      = stall[2];
    assign bus.mem_stall_o     = stall[1];
    assign bus.wb_stall_o      = stall[0];
    assign bus.id_flush_o      = flush[2];
    assign bus.ex_flush_o      = flush[1];
    assign bus.mem_flush_o     = flush[0];
    assign bus.pc_trap_o       = pc_trap;
    assign bus.drain_timeout_o = drain_timeout;
    assign bus.state_o         = state;

`ifdef TITAN_PIPE_PERF_EN
    localparam logic [PERF_W-1:0] CNT_MAX = '1;

    logic [PERF_W-1:0] ld_cnt;
    logic [PERF_W-1:0] csr_cnt;
    logic [PERF_W-1:0] trap_cnt;
    logic              enter_redir;

    assign enter_redir = (state_next == REDIR) && (state != REDIR);

    // Saturating event counters, frozen during memory waits like the rest of the state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ld_cnt   <= '0;
            csr_cnt  <= '0;
            trap_cnt <= '0;
        end else if (!mw) begin
            if (bus.ld_stall_req_i && !tr && ld_cnt != CNT_MAX) begin
                ld_cnt <= ld_cnt + 1'b1;
            end
            if (bus.csr_stall_req_i && !tr && csr_cnt != CNT_MAX) begin
                csr_cnt <= csr_cnt + 1'b1;
            end
            if (enter_redir && trap_cnt != CNT_MAX) begin
                trap_cnt <= trap_cnt + 1'b1;
            end
        end
    end

    assign bus.ld_stall_cnt_o  = ld_cnt;
    assign bus.csr_stall_cnt_o = csr_cnt;
    assign bus.trap_cnt_o      = trap_cnt;
`else
    assign bus.ld_stall_cnt_o  = {PERF_W{1'b0}};
    assign bus.csr_stall_cnt_o = {PERF_W{1'b0}};
    assign bus.trap_cnt_o      = {PERF_W{1'b0}};
`endif
endmodule

// File: tb/tb_titan_pipeline_ctrl.sv
// Self-checking bench for titan_pipeline_ctrl: directed vectors, a per-cycle reference model
// and hand-computed literal checks. Counter expectations follow TITAN_PIPE_PERF_EN.
module tb_titan_pipeline_ctrl;
    localparam int MAX_DRAIN = 4;
    localparam int PERF_W    = 32;
`ifdef TITAN_PIPE_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif
    localparam longint CNT_MAX = (64'd1 << PERF_W) - 1;

    // Control vector: {if,id,ex,mem,wb stall, id,ex,mem flush, pc_trap, drain_timeout}
    localparam logic [9:0] C_IDLE  = 10'b00000_000_00;
    localparam logic [9:0] C_MWAIT = 10'b11111_000_00;
    localparam logic [9:0] C_HAZ   = 10'b11000_010_00;
    localparam logic [9:0] C_DRAIN = 10'b10000_100_00;
    localparam logic [9:0] C_WDOG  = 10'b10000_100_01;
    localparam logic [9:0] C_REDIR = 10'b00000_111_10;

    bit   clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   failCount  = 0;
    bit   checkEn    = 1'b0;

    titan_pipeline_ctrl_if #(.PERF_W(PERF_W)) bus ();

    titan_pipeline_ctrl #(
        .MAX_DRAIN (MAX_DRAIN),
        .PERF_W    (PERF_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [9:0] ctrl;
    assign ctrl = {bus.if_stall_o, bus.id_stall_o, bus.ex_stall_o, bus.mem_stall_o,
                   bus.wb_stall_o, bus.id_flush_o, bus.ex_flush_o, bus.mem_flush_o,
                   bus.pc_trap_o, bus.drain_timeout_o};

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    function automatic longint perfExp(input longint v);
        return PERF_ON ? v : 64'd0;
    endfunction

    // Reference model: phase (0 run, 1 hazard, 2 drain, 3 redirect), drain age, event counts
    int     mPhase = 0;
    int     mAge   = 0;
    longint mLd    = 0;
    longint mCsr   = 0;
    longint mTrap  = 0;

    always @(negedge clk) begin
        if (checkEn) begin
            logic [9:0] expCtrl;
            bit memWait, hazReq, trapReq, toRedirect;
            memWait = !bus.imem_ready_i || !bus.dmem_ready_i;
            hazReq  = bus.ld_stall_req_i || bus.csr_stall_req_i;
            trapReq = bus.xcall_break_stall_req_i || bus.illegal_stall_req_i;

            if (rst)                      expCtrl = C_IDLE;
            else if (memWait)             expCtrl = C_MWAIT;
            else if (mPhase == 3)         expCtrl = C_REDIR;
            else if (mPhase == 2)         expCtrl = (!bus.trap_commit_i && mAge == MAX_DRAIN - 1) ? C_WDOG : C_DRAIN;
            else if (trapReq)             expCtrl = C_DRAIN;
            else if (hazReq)              expCtrl = C_HAZ;
            else                          expCtrl = C_IDLE;

            checkOutput("cyc_ctrl", 64'(ctrl), 64'(expCtrl));
            checkOutput("cyc_state", 64'(bus.state_o), 64'(mPhase));
            checkOutput("cyc_ld_cnt", 64'(bus.ld_stall_cnt_o), perfExp(mLd));
            checkOutput("cyc_csr_cnt", 64'(bus.csr_stall_cnt_o), perfExp(mCsr));
            checkOutput("cyc_trap_cnt", 64'(bus.trap_cnt_o), perfExp(mTrap));

            if (rst) begin
                mPhase = 0; mAge = 0; mLd = 0; mCsr = 0; mTrap = 0;
            end else if (!memWait) begin
                if (bus.ld_stall_req_i && !trapReq && mLd < CNT_MAX) mLd++;
                if (bus.csr_stall_req_i && !trapReq && mCsr < CNT_MAX) mCsr++;
                toRedirect = (mPhase == 2) && (bus.trap_commit_i || mAge == MAX_DRAIN - 1);
                if (mPhase == 3) begin
                    mPhase = 0;
                    mAge   = 0;
                end else if (mPhase == 2) begin
                    mAge++;
                    if (toRedirect) mPhase = 3;
                end else begin
                    mPhase = trapReq ? 2 : (hazReq ? 1 : 0);
                end
                if (toRedirect && mTrap < CNT_MAX) mTrap++;
            end
        end
    end

    // Drive one cycle of inputs just after a rising edge, return just after the falling edge
    task automatic applyStimulus(input logic r, input logic ld, input logic csr, input logic xb,
                                 input logic ill, input logic commit, input logic imem,
                                 input logic dmem);
        @(posedge clk);
        #1;
        rst                         = r;
        bus.ld_stall_req_i          = ld;
        bus.csr_stall_req_i         = csr;
        bus.xcall_break_stall_req_i = xb;
        bus.illegal_stall_req_i     = ill;
        bus.trap_commit_i           = commit;
        bus.imem_ready_i            = imem;
        bus.dmem_ready_i            = dmem;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic xcall();
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 1);
    endtask

    initial begin
        rst                         = 1'b1;
        bus.ld_stall_req_i          = 1'b0;
        bus.csr_stall_req_i         = 1'b0;
        bus.xcall_break_stall_req_i = 1'b0;
        bus.illegal_stall_req_i     = 1'b0;
        bus.trap_commit_i           = 1'b0;
        bus.imem_ready_i            = 1'b1;
        bus.dmem_ready_i            = 1'b1;
        @(posedge clk);
        #1;
        checkEn = 1'b1;

        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("reset_ctrl", 64'(ctrl), 64'(C_IDLE));
        checkOutput("reset_state", 64'(bus.state_o), 64'd0);
        checkOutput("reset_trap_cnt", 64'(bus.trap_cnt_o), 64'd0);

        // Load-use stall for two cycles, then release
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 1);
        checkOutput("lu_ctrl1", 64'(ctrl), 64'(10'b11000_010_00));
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 1);
        checkOutput("lu_ctrl2", 64'(ctrl), 64'(10'b11000_010_00));
        checkOutput("lu_state2", 64'(bus.state_o), 64'd1);
        idle();
        checkOutput("lu_release", 64'(ctrl), 64'd0);
        idle();
        checkOutput("lu_state_run", 64'(bus.state_o), 64'd0);
        checkOutput("lu_ld_cnt", 64'(bus.ld_stall_cnt_o), perfExp(2));

        // Memory wait outranks a hazard and freezes the counters
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
        checkOutput("mw_haz_ctrl", 64'(ctrl), 64'(10'b11111_000_00));
        idle();
        checkOutput("mw_haz_ld_cnt", 64'(bus.ld_stall_cnt_o), perfExp(2));

        // Both hazard requests count together
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 1);
        idle();
        idle();
        checkOutput("csr_ld_cnt", 64'(bus.ld_stall_cnt_o), perfExp(3));
        checkOutput("csr_csr_cnt", 64'(bus.csr_stall_cnt_o), perfExp(1));

        // Illegal trap with commit two cycles after detection
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 1);
        checkOutput("ill_t0_ctrl", 64'(ctrl), 64'(10'b10000_100_00));
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 1);
        checkOutput("ill_t1_state", 64'(bus.state_o), 64'd2);
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 1);
        checkOutput("ill_t2_ctrl", 64'(ctrl), 64'(10'b10000_100_00));
        idle();
        checkOutput("ill_t3_ctrl", 64'(ctrl), 64'(10'b00000_111_10));
        checkOutput("ill_t3_state", 64'(bus.state_o), 64'd3);
        idle();
        checkOutput("ill_t4_state", 64'(bus.state_o), 64'd0);
        checkOutput("ill_trap_cnt", 64'(bus.trap_cnt_o), perfExp(1));

        // Watchdog: xcall held, no commit, MAX_DRAIN = 4
        xcall();
        xcall();
        xcall();
        xcall();
        checkOutput("wd_d3_ctrl", 64'(ctrl), 64'(10'b10000_100_00));
        xcall();
        checkOutput("wd_d4_ctrl", 64'(ctrl), 64'(10'b10000_100_01));
        checkOutput("wd_d4_state", 64'(bus.state_o), 64'd2);
        idle();
        checkOutput("wd_redir_ctrl", 64'(ctrl), 64'(10'b00000_111_10));
        idle();
        checkOutput("wd_trap_cnt", 64'(bus.trap_cnt_o), perfExp(2));

        // Three-cycle data-memory wait in the middle of a drain
        xcall();
        xcall();
        xcall();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 1, 0);
            checkOutput("mwd_ctrl", 64'(ctrl), 64'(10'b11111_000_00));
            checkOutput("mwd_state", 64'(bus.state_o), 64'd2);
        end
        xcall();
        checkOutput("mwd_d3_ctrl", 64'(ctrl), 64'(10'b10000_100_00));
        xcall();
        checkOutput("mwd_d4_ctrl", 64'(ctrl), 64'(10'b10000_100_01));
        idle();
        checkOutput("mwd_redir_ctrl", 64'(ctrl), 64'(10'b00000_111_10));
        idle();

        // Load-use and illegal together: trap wins, no load-use count
        applyStimulus(0, 1, 0, 0, 1, 0, 1, 1);
        checkOutput("sim_ctrl", 64'(ctrl), 64'(10'b10000_100_00));
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 1);
        checkOutput("sim_state", 64'(bus.state_o), 64'd2);
        idle();
        idle();
        checkOutput("sim_ld_cnt", 64'(bus.ld_stall_cnt_o), perfExp(3));
        checkOutput("sim_trap_cnt", 64'(bus.trap_cnt_o), perfExp(4));

        // Reset during a drain, right where the watchdog would otherwise fire
        xcall();
        xcall();
        xcall();
        xcall();
        applyStimulus(1, 0, 0, 1, 0, 0, 1, 1);
        checkOutput("rst_drain_ctrl", 64'(ctrl), 64'd0);
        idle();
        checkOutput("rst_drain_state", 64'(bus.state_o), 64'd0);
        checkOutput("rst_drain_outs", 64'(ctrl), 64'd0);
        checkOutput("rst_drain_ld_cnt", 64'(bus.ld_stall_cnt_o), 64'd0);
        idle();
        checkOutput("rst_no_trap", 64'(bus.pc_trap_o), 64'd0);

        @(posedge clk);
        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule
